// File: rtl/instruction_fetch_pkg.sv
// Shared IF-stage definitions: special instruction words and the next-PC source encoding.
package instruction_fetch_pkg;

  localparam logic [31:0] HALT_OP = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_INC    = 2'd0,
    PC_HOLD   = 2'd1,
    PC_JUMP   = 2'd2,
    PC_BRANCH = 2'd3
  } pc_sel_e;

  // Every source except a hold moves the PC and counts as a fetch.
  function automatic logic pc_advances(input pc_sel_e sel);
    return sel != PC_HOLD;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Combinational-read instruction ROM; word k of INIT_IMAGE occupies bits [k*B +: B].
module instruction_memory
  import instruction_fetch_pkg::*;
#(
  parameter int B = 32,
  parameter int W = 7,
  parameter logic [(2**W)*B-1:0] INIT_IMAGE = {(2**W){NOP[B-1:0]}}
) (
  input  logic [W-1:0] addr,
  output logic [B-1:0] data
);

  logic [B-1:0] w_rom [2**W];

  always_comb begin
    for (int k = 0; k < 2**W; k++) begin
      w_rom[k] = INIT_IMAGE[k*B +: B];
    end
  end

  assign data = w_rom[addr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, prioritised next-PC mux, sticky HALT flag and saturating fetch counter.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int B  = 32,
  parameter int W  = 7,
  parameter int CW = 16,
  parameter logic [(2**W)*B-1:0] INIT_IMAGE = {(2**W){NOP[B-1:0]}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          jump,
  input  logic [B-1:0]  jump_target,
  input  logic          branch_taken,
  input  logic [B-1:0]  branch_target,
  output logic [W-1:0]  pc,
  output logic [B-1:0]  pc_incrementado,
  output logic [B-1:0]  instruction,
  output logic          halted,
  output logic [CW-1:0] fetch_count
);

  logic [W-1:0]  r_pc;
  logic          r_halted;
  logic [CW-1:0] r_fetch_count;

  logic [W-1:0]  w_pc_next;
  logic [W-1:0]  w_pc_plus1;
  logic [B-1:0]  w_instr;
  logic          w_is_halt;
  logic          w_halted_next;
  pc_sel_e       w_sel;
  logic          w_unused_hi;

  instruction_memory #(
    .B          (B),
    .W          (W),
    .INIT_IMAGE (INIT_IMAGE)
  ) u_imem (
    .addr (r_pc),
    .data (w_instr)
  );

  assign w_pc_plus1  = r_pc + W'(1);
  assign w_is_halt   = (w_instr == HALT_OP[B-1:0]);
  // Targets are full datapath words; only the low W bits address the ROM.
  assign w_unused_hi = ^{jump_target[B-1:W], branch_target[B-1:W]};

  // Branch resolves in MEM, so it belongs to an older instruction than the jump in ID.
  always_comb begin
    w_sel = PC_INC;
    if (branch_taken)                     w_sel = PC_BRANCH;
    else if (jump)                        w_sel = PC_JUMP;
    else if (r_halted || w_is_halt || stall) w_sel = PC_HOLD;
  end

  always_comb begin
    w_pc_next = r_pc;
    case (w_sel)
      PC_BRANCH: w_pc_next = branch_target[W-1:0];
      PC_JUMP:   w_pc_next = jump_target[W-1:0];
      PC_INC:    w_pc_next = w_pc_plus1;
      default:   w_pc_next = r_pc;
    endcase
  end

  // A redirect means any HALT seen so far was on the wrong path.
  always_comb begin
    w_halted_next = r_halted;
    if (branch_taken || jump)    w_halted_next = 1'b0;
    else if (w_is_halt && !stall) w_halted_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= '0;
      r_halted      <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_pc     <= w_pc_next;
      r_halted <= w_halted_next;
      if (pc_advances(w_sel) && (r_fetch_count != '1)) begin
        r_fetch_count <= r_fetch_count + CW'(1);
      end
    end
  end

  assign pc              = r_pc;
  assign pc_incrementado = {{(B-W){1'b0}}, w_pc_plus1};
  assign instruction     = w_instr;
  assign halted          = r_halted;
  assign fetch_count     = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random control traffic against a PC model.
module tb_instruction_fetch;

  localparam int B     = 32;
  localparam int W     = 7;
  localparam int CW    = 16;
  localparam int DEPTH = 128;
  localparam int SAT   = 65535;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  function automatic logic [31:0] word_at(input int k);
    logic [7:0]  kb;
    logic [31:0] w;
    kb = k[7:0];
    if (k < 4 || k == 127)                             w = 32'h0;
    else if (k == 4 || k == 10 || k == 50 || k == 90)  w = HALT;
    else                                               w = {kb, 8'hA5, ~kb, 8'h3C};
    return w;
  endfunction

  function automatic logic [DEPTH*B-1:0] build_image();
    logic [DEPTH*B-1:0] img;
    img = '0;
    for (int k = 0; k < DEPTH; k++) img[k*B +: B] = word_at(k);
    return img;
  endfunction

  localparam logic [DEPTH*B-1:0] IMAGE = build_image();

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          jump;
  logic [B-1:0]  jump_target;
  logic          branch_taken;
  logic [B-1:0]  branch_target;
  logic [W-1:0]  pc;
  logic [B-1:0]  pc_incrementado;
  logic [B-1:0]  instruction;
  logic          halted;
  logic [CW-1:0] fetch_count;

  instruction_fetch #(
    .B          (B),
    .W          (W),
    .CW         (CW),
    .INIT_IMAGE (IMAGE)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .jump            (jump),
    .jump_target     (jump_target),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .pc              (pc),
    .pc_incrementado (pc_incrementado),
    .instruction     (instruction),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_mem [DEPTH];
  int          m_pc;
  bit          m_halted;
  int          m_count;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc     = 0;
    m_halted = 1'b0;
    m_count  = 0;
  endtask

  // Reference: one rising edge of the IF stage, straight from the priority rules.
  task automatic model_step(input bit st, input bit jp, input logic [31:0] jt,
                            input bit br, input logic [31:0] bt);
    bit moved;
    moved = 1'b1;
    if (br) begin
      m_pc     = int'(bt % 32'd128);
      m_halted = 1'b0;
    end else if (jp) begin
      m_pc     = int'(jt % 32'd128);
      m_halted = 1'b0;
    end else if (m_halted || m_mem[m_pc] == HALT) begin
      if (!st) m_halted = 1'b1;
      moved = 1'b0;
    end else if (st) begin
      moved = 1'b0;
    end else begin
      m_pc = (m_pc + 1) % DEPTH;
    end
    if (moved && m_count < SAT) m_count = m_count + 1;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".pc"},     32'(pc),          32'(m_pc));
    check_eq({tag, ".instr"},  instruction,      m_mem[m_pc]);
    check_eq({tag, ".pc_inc"}, pc_incrementado,  32'((m_pc + 1) % DEPTH));
    check_eq({tag, ".halted"}, 32'(halted),      32'(m_halted));
    check_eq({tag, ".count"},  32'(fetch_count), 32'(m_count));
  endtask

  // Called 1 time unit after an edge; inputs are applied then, checked 1 unit after the next edge.
  task automatic step(input bit st, input bit jp, input logic [31:0] jt,
                      input bit br, input logic [31:0] bt, input bit do_chk);
    stall = st; jump = jp; jump_target = jt; branch_taken = br; branch_target = bt;
    @(posedge clk);
    model_step(st, jp, jt, br, bt);
    #1;
    if (do_chk) check_all("step");
  endtask

  task automatic sync_reset();
    stall = 0; jump = 0; branch_taken = 0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) m_mem[k] = word_at(k);
    reset = 1'b1; stall = 0; jump = 0; branch_taken = 0;
    jump_target = '0; branch_target = '0;
    model_reset();
    #12;
    check_eq("rst_pc",     32'(pc),          32'd0);
    check_eq("rst_pc_inc", pc_incrementado,  32'd1);
    check_eq("rst_instr",  instruction,      32'd0);
    check_eq("rst_count",  32'(fetch_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // free run into the HALT at address 4
    repeat (6) step(0, 0, 0, 0, 0, 1);
    check_eq("t1_pc",     32'(pc),          32'd4);
    check_eq("t1_halted", 32'(halted),      32'd1);
    check_eq("t1_count",  32'(fetch_count), 32'd4);

    // stall holds pc and counter
    sync_reset();
    repeat (2) step(0, 0, 0, 0, 0, 1);
    repeat (2) step(1, 0, 0, 0, 0, 1);
    check_eq("t2_pc",    32'(pc),          32'd2);
    check_eq("t2_count", 32'(fetch_count), 32'd2);
    step(0, 0, 0, 0, 0, 1);
    check_eq("t2_release_pc", 32'(pc), 32'd3);

    // branch beats jump, then jump alone
    step(0, 1, 32'd5, 0, 0, 1);
    step(0, 1, 32'h20, 1, 32'h40, 1);
    check_eq("t3_branch_wins", 32'(pc), 32'h40);
    step(0, 1, 32'h20, 0, 0, 1);
    check_eq("t3_jump", 32'(pc), 32'h20);

    // wrong-path halt cancelled by a branch; stall masks a HALT
    step(0, 1, 32'd10, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check_eq("t4_halted_set", 32'(halted), 32'd1);
    step(0, 0, 0, 1, 32'd3, 1);
    check_eq("t4_redirect_pc",     32'(pc),     32'd3);
    check_eq("t4_redirect_halted", 32'(halted), 32'd0);
    step(0, 1, 32'd10, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    check_eq("t4_stall_halt", 32'(halted), 32'd0);
    step(0, 0, 0, 0, 0, 1);

    // wrap at the top of the address space, upper target bits ignored
    step(0, 1, 32'hABCD_007F, 0, 0, 1);
    check_eq("t5_pc",     32'(pc),         32'd127);
    check_eq("t5_pc_inc", pc_incrementado, 32'd0);
    step(0, 0, 0, 0, 0, 1);
    check_eq("t5_wrap_pc", 32'(pc), 32'd0);

    // asynchronous reset mid-cycle at pc=9, count=9
    sync_reset();
    repeat (5) step(0, 1, 32'd5, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 0, 1);
    check_eq("t6_pre_pc",    32'(pc),          32'd9);
    check_eq("t6_pre_count", 32'(fetch_count), 32'd9);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("t6_async_pc",     32'(pc),          32'd0);
    check_eq("t6_async_count",  32'(fetch_count), 32'd0);
    check_eq("t6_async_pc_inc", pc_incrementado,  32'd1);
    #1;
    reset = 1'b0;
    check_eq("t6_first_fetch", instruction, m_mem[0]);
    step(1, 0, 0, 1, 32'd7, 1);
    check_eq("t6_stall_branch", 32'(pc), 32'd7);

    // random control traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        sync_reset();
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom(),
             $urandom_range(0, 11) == 0, $urandom(), 1);
      end
    end

    // counter saturation under continuous redirects
    sync_reset();
    for (int i = 0; i < SAT + 5; i++) step(0, 1, 32'h20, 0, 0, 0);
    check_all("sat");
    check_eq("sat_count", 32'(fetch_count), 32'(SAT));
    step(0, 0, 0, 0, 0, 1);
    check_eq("sat_hold_count", 32'(fetch_count), 32'(SAT));
    check_eq("sat_pc",         32'(pc),          32'h21);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
